// File: rtl/mem_access_ctrl.sv
// Load/store initiator for the byte-addressed 256x8 data RAM: strobes the bus, waits for done, extends load data.
// Optional feature macro: ALIGN_CHECK_EN (reject misaligned half/word requests without touching the bus).
module mem_access_ctrl #(
    parameter int TIMEOUT_CYCLES = 64
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_rw,
    input  logic [1:0]  req_size,
    input  logic        req_signed,
    input  logic [7:0]  req_addr,
    input  logic [31:0] req_wdata,
    output logic        rsp_valid,
    output logic        rsp_err,
    output logic [31:0] rsp_rdata,
    output logic        busy,
    output logic        mem_enable,
    output logic        mem_rw,
    output logic [1:0]  mem_dataType,
    output logic [7:0]  mem_address,
    output logic [31:0] mem_dataIn,
    input  logic [31:0] mem_dataOut,
    input  logic        mem_done
);

    localparam logic [1:0] S_IDLE      = 2'd0;
    localparam logic [1:0] S_WAIT_LOW  = 2'd1;
    localparam logic [1:0] S_WAIT_HIGH = 2'd2;
    localparam logic [1:0] S_DONE      = 2'd3;

    localparam logic [7:0] TO_LIMIT = 8'(TIMEOUT_CYCLES);

    function automatic logic [31:0] extend_load(input logic [1:0] size, input logic sgn,
                                                input logic [31:0] d);
        case (size)
            2'b00:   return {{24{sgn & d[7]}}, d[7:0]};
            2'b01:   return {{16{sgn & d[15]}}, d[15:0]};
            default: return d;
        endcase
    endfunction

    logic [1:0]  r_state;
    logic [7:0]  r_cnt;
    logic        r_signed;
    logic        r_mem_enable;
    logic        r_mem_rw;
    logic [1:0]  r_mem_dataType;
    logic [7:0]  r_mem_address;
    logic [31:0] r_mem_dataIn;
    logic        r_rsp_valid;
    logic        r_rsp_err;
    logic [31:0] r_rsp_rdata;

    logic        w_idle;
    logic        w_accept;
    logic        w_misalign;
    logic        w_reject;
    logic [7:0]  w_cnt_next;
    logic        w_timeout;

    assign w_idle     = (r_state == S_IDLE);
    assign w_accept   = req_valid & w_idle;
    assign w_cnt_next = r_cnt + 8'd1;
    assign w_timeout  = (w_cnt_next == TO_LIMIT);

`ifdef ALIGN_CHECK_EN
    assign w_misalign = ((req_size == 2'b01) & req_addr[0]) |
                        ((req_size == 2'b10) & (req_addr[1:0] != 2'b00));
`else
    assign w_misalign = 1'b0;
`endif

    assign w_reject = (req_size == 2'b11) | w_misalign;

    assign req_ready    = w_idle;
    assign busy         = ~w_idle;
    assign mem_enable   = r_mem_enable;
    assign mem_rw       = r_mem_rw;
    assign mem_dataType = r_mem_dataType;
    assign mem_address  = r_mem_address;
    assign mem_dataIn   = r_mem_dataIn;
    assign rsp_valid    = r_rsp_valid;
    assign rsp_err      = r_rsp_err;
    assign rsp_rdata    = r_rsp_rdata;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state        <= S_IDLE;
            r_cnt          <= 8'd0;
            r_signed       <= 1'b0;
            r_mem_enable   <= 1'b0;
            r_mem_rw       <= 1'b0;
            r_mem_dataType <= 2'b00;
            r_mem_address  <= 8'd0;
            r_mem_dataIn   <= 32'd0;
            r_rsp_valid    <= 1'b0;
            r_rsp_err      <= 1'b0;
            r_rsp_rdata    <= 32'd0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (w_accept) begin
                        r_mem_rw       <= req_rw;
                        r_mem_dataType <= req_size;
                        r_mem_address  <= req_addr;
                        r_mem_dataIn   <= req_wdata;
                        r_signed       <= req_signed;
                        r_cnt          <= 8'd0;
                        if (w_reject) begin
                            r_rsp_valid <= 1'b1;
                            r_rsp_err   <= 1'b1;
                            r_rsp_rdata <= 32'd0;
                            r_state     <= S_DONE;
                        end else begin
                            r_mem_enable <= 1'b1;
                            r_state      <= S_WAIT_LOW;
                        end
                    end
                end
                // A done left high by the previous access must fall before completion can be recognised.
                S_WAIT_LOW: begin
                    r_cnt <= w_cnt_next;
                    if (w_timeout) begin
                        r_mem_enable <= 1'b0;
                        r_rsp_valid  <= 1'b1;
                        r_rsp_err    <= 1'b1;
                        r_rsp_rdata  <= 32'd0;
                        r_state      <= S_DONE;
                    end else if (!mem_done) begin
                        r_state <= S_WAIT_HIGH;
                    end
                end
                S_WAIT_HIGH: begin
                    r_cnt <= w_cnt_next;
                    if (mem_done) begin
                        r_mem_enable <= 1'b0;
                        r_rsp_valid  <= 1'b1;
                        r_rsp_err    <= 1'b0;
                        r_rsp_rdata  <= r_mem_rw ? 32'd0
                                                 : extend_load(r_mem_dataType, r_signed, mem_dataOut);
                        r_state      <= S_DONE;
                    end else if (w_timeout) begin
                        r_mem_enable <= 1'b0;
                        r_rsp_valid  <= 1'b1;
                        r_rsp_err    <= 1'b1;
                        r_rsp_rdata  <= 32'd0;
                        r_state      <= S_DONE;
                    end
                end
                S_DONE: begin
                    r_rsp_valid <= 1'b0;
                    r_rsp_err   <= 1'b0;
                    r_rsp_rdata <= 32'd0;
                    r_state     <= S_IDLE;
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_mem_access_ctrl.sv
// Bench for mem_access_ctrl: RAM responder stub plus a byte-array reference model of memory and extension rules.
module tb_mem_access_ctrl;

`ifdef ALIGN_CHECK_EN
    localparam bit ALIGN = 1'b1;
`else
    localparam bit ALIGN = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        req_valid = 1'b0;
    logic        req_ready;
    logic        req_rw = 1'b0;
    logic [1:0]  req_size = 2'b00;
    logic        req_signed = 1'b0;
    logic [7:0]  req_addr = 8'd0;
    logic [31:0] req_wdata = 32'd0;
    logic        rsp_valid;
    logic        rsp_err;
    logic [31:0] rsp_rdata;
    logic        busy;
    logic        mem_enable;
    logic        mem_rw;
    logic [1:0]  mem_dataType;
    logic [7:0]  mem_address;
    logic [31:0] mem_dataIn;
    logic [31:0] mem_dataOut;
    logic        mem_done;

    mem_access_ctrl #(.TIMEOUT_CYCLES(8)) dut (
        .clk(clk), .reset(rst),
        .req_valid(req_valid), .req_ready(req_ready), .req_rw(req_rw), .req_size(req_size),
        .req_signed(req_signed), .req_addr(req_addr), .req_wdata(req_wdata),
        .rsp_valid(rsp_valid), .rsp_err(rsp_err), .rsp_rdata(rsp_rdata), .busy(busy),
        .mem_enable(mem_enable), .mem_rw(mem_rw), .mem_dataType(mem_dataType),
        .mem_address(mem_address), .mem_dataIn(mem_dataIn), .mem_dataOut(mem_dataOut),
        .mem_done(mem_done)
    );

    always #5 clk = ~clk;

    // RAM responder: mode 0 normal, 1 done stuck high, 2 done stuck low.
    logic [7:0]  ram [256];
    int          ram_mode = 0;
    bit          ram_init = 1'b0;
    logic        ram_act;
    logic        ram_done_q;
    int          ram_lat;
    logic [31:0] ram_rd;
    logic [7:0]  a1, a2, a3;

    assign a1 = mem_address + 8'd1;
    assign a2 = mem_address + 8'd2;
    assign a3 = mem_address + 8'd3;
    assign mem_done    = ram_done_q;
    assign mem_dataOut = ram_rd;

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            ram_act    <= 1'b0;
            ram_done_q <= 1'b1;
            ram_lat    <= 0;
            ram_rd     <= 32'd0;
        end else if (!ram_init) begin
            for (int i = 0; i < 256; i++) ram[i] <= 8'(i) ^ 8'hA5;
            ram_init <= 1'b1;
        end else if (ram_mode == 1) begin
            ram_done_q <= 1'b1;
        end else if (mem_enable && !ram_act) begin
            ram_act    <= 1'b1;
            ram_done_q <= 1'b0;
            ram_lat    <= $urandom_range(0, 3);
        end else if (ram_act && mem_enable && !ram_done_q && ram_mode == 0) begin
            if (ram_lat == 0) begin
                ram_done_q <= 1'b1;
                if (mem_rw) begin
                    case (mem_dataType)
                        2'b00: ram[mem_address] <= mem_dataIn[7:0];
                        2'b01: begin
                            ram[mem_address] <= mem_dataIn[15:8];
                            ram[a1]          <= mem_dataIn[7:0];
                        end
                        default: begin
                            ram[mem_address] <= mem_dataIn[31:24];
                            ram[a1]          <= mem_dataIn[23:16];
                            ram[a2]          <= mem_dataIn[15:8];
                            ram[a3]          <= mem_dataIn[7:0];
                        end
                    endcase
                end else begin
                    case (mem_dataType)
                        2'b00:   ram_rd <= {24'd0, ram[mem_address]};
                        2'b01:   ram_rd <= {16'd0, ram[mem_address], ram[a1]};
                        default: ram_rd <= {ram[mem_address], ram[a1], ram[a2], ram[a3]};
                    endcase
                end
            end else begin
                ram_lat <= ram_lat - 1;
            end
        end else if (!mem_enable) begin
            ram_act <= 1'b0;
        end
    end

    // Reference model: expected memory contents as plain bytes.
    logic [7:0] ref_mem [256];

    function automatic int nbytes(input logic [1:0] sz);
        return (sz == 2'b00) ? 1 : (sz == 2'b01) ? 2 : 4;
    endfunction

    function automatic logic [31:0] model_load(input logic [1:0] sz, input logic sg, input logic [7:0] ad);
        int n = nbytes(sz);
        longint v = 0;
        for (int i = 0; i < n; i++) v = v * 256 + longint'(ref_mem[(int'(ad) + i) % 256]);
        if (sg && n < 4 && v >= (longint'(1) << (8 * n - 1)))
            v = v + (longint'(1) << 32) - (longint'(1) << (8 * n));
        return 32'(v);
    endfunction

    task automatic model_store(input logic [1:0] sz, input logic [7:0] ad, input logic [31:0] wd);
        int n = nbytes(sz);
        for (int i = 0; i < n; i++)
            ref_mem[(int'(ad) + i) % 256] = 8'((wd >> (8 * (n - 1 - i))) & 32'hFF);
    endtask

    function automatic bit misaligned(input logic [1:0] sz, input logic [7:0] ad);
        return (sz == 2'b01 && ad[0]) || (sz == 2'b10 && ad[1:0] != 2'b00);
    endfunction

    int n_cmp = 0;
    int n_mis = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp)
        else begin
            n_mis++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    logic        res_err;
    logic [31:0] res_data;
    int          res_lat;
    int          res_pulses;
    logic        res_en_seen;
    logic        res_bus_ok;
    logic        res_en_at_rsp;

    task automatic do_req(input logic rw, input logic [1:0] sz, input logic sg,
                          input logic [7:0] ad, input logic [31:0] wd);
        int  t;
        bit  got;
        @(negedge clk);
        req_valid = 1'b1; req_rw = rw; req_size = sz; req_signed = sg; req_addr = ad; req_wdata = wd;
        t = 0;
        while (!req_ready && t < 50) begin
            @(negedge clk);
            t++;
        end
        @(posedge clk);
        #1;
        req_valid  = 1'b0;
        req_rw     = ~rw;
        req_size   = 2'($urandom_range(0, 3));
        req_addr   = 8'($urandom_range(0, 255));
        req_wdata  = $urandom;
        res_err = 1'bx; res_data = 32'hxxxxxxxx; res_lat = 0; res_pulses = 0;
        res_en_seen = 1'b0; res_bus_ok = 1'b1; res_en_at_rsp = 1'bx;
        got = 1'b0;
        while (!got && res_lat < 60) begin
            @(negedge clk);
            if (mem_enable) begin
                res_en_seen = 1'b1;
                if (mem_address !== ad || mem_rw !== rw || mem_dataType !== sz || mem_dataIn !== wd)
                    res_bus_ok = 1'b0;
            end
            if (rsp_valid) begin
                got = 1'b1;
                res_err = rsp_err;
                res_data = rsp_rdata;
                res_en_at_rsp = mem_enable;
                res_pulses++;
            end else begin
                res_lat++;
            end
        end
        @(negedge clk);
        if (rsp_valid) res_pulses++;
    endtask

    task automatic run_checked(input string tag, input logic rw, input logic [1:0] sz, input logic sg,
                               input logic [7:0] ad, input logic [31:0] wd);
        bit          exp_err = (sz == 2'b11) || (ALIGN && misaligned(sz, ad));
        logic [31:0] exp_data = (exp_err || rw) ? 32'd0 : model_load(sz, sg, ad);
        do_req(rw, sz, sg, ad, wd);
        if (!exp_err && rw) model_store(sz, ad, wd);
        check({tag, "_err"}, 32'(res_err), 32'(exp_err));
        check({tag, "_data"}, res_data, exp_data);
        check({tag, "_pulses"}, 32'(res_pulses), 32'd1);
        check({tag, "_bus"}, 32'(res_en_seen), 32'(!exp_err));
        check({tag, "_en_at_rsp"}, 32'(res_en_at_rsp), 32'd0);
        if (!exp_err) check({tag, "_busfields"}, 32'(res_bus_ok), 32'd1);
    endtask

    initial begin
        for (int i = 0; i < 256; i++) ref_mem[i] = 8'(i) ^ 8'hA5;

        // Reset state
        repeat (3) @(negedge clk);
        check("rst_ready", 32'(req_ready), 32'd1);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_enable", 32'(mem_enable), 32'd0);
        check("rst_rsp_valid", 32'(rsp_valid), 32'd0);
        check("rst_rsp_err", 32'(rsp_err), 32'd0);
        check("rst_rdata", rsp_rdata, 32'd0);
        check("rst_addr", {24'd0, mem_address}, 32'd0);
        check("rst_dataIn", mem_dataIn, 32'd0);
        rst = 1'b0;
        repeat (2) @(negedge clk);

        // Store word then read back
        run_checked("st_word", 1'b1, 2'b10, 1'b0, 8'h10, 32'hDEADBEEF);
        do_req(1'b0, 2'b10, 1'b0, 8'h10, 32'd0);
        check("ld_word", res_data, 32'hDEADBEEF);
        check("ld_word_err", 32'(res_err), 32'd0);
        check("ld_word_pulses", 32'(res_pulses), 32'd1);

        // Sign/zero extension
        do_req(1'b0, 2'b00, 1'b1, 8'h10, 32'd0);
        check("ld_byte_s", res_data, 32'hFFFFFFDE);
        do_req(1'b0, 2'b00, 1'b0, 8'h10, 32'd0);
        check("ld_byte_u", res_data, 32'h000000DE);
        do_req(1'b0, 2'b01, 1'b1, 8'h12, 32'd0);
        check("ld_half_s", res_data, 32'hFFFFBEEF);
        do_req(1'b0, 2'b01, 1'b0, 8'h12, 32'd0);
        check("ld_half_u", res_data, 32'h0000BEEF);

        // Done stuck high: timeout after 8 wait cycles
        ram_mode = 1;
        do_req(1'b0, 2'b10, 1'b0, 8'h40, 32'd0);
        check("to_err", 32'(res_err), 32'd1);
        check("to_lat", 32'(res_lat), 32'd8);
        check("to_data", res_data, 32'd0);
        check("to_en", 32'(res_en_at_rsp), 32'd0);
        check("to_bus", 32'(res_en_seen), 32'd1);
        ram_mode = 0;
        repeat (2) @(negedge clk);

        // Reset while waiting for done
        ram_mode = 2;
        @(negedge clk);
        req_valid = 1'b1; req_rw = 1'b0; req_size = 2'b10; req_addr = 8'h30;
        @(posedge clk);
        #1 req_valid = 1'b0;
        repeat (3) @(negedge clk);
        check("mid_enable_before", 32'(mem_enable), 32'd1);
        #2 rst = 1'b1;
        #1;
        check("mid_enable_after", 32'(mem_enable), 32'd0);
        check("mid_ready", 32'(req_ready), 32'd1);
        res_pulses = 0;
        repeat (4) begin
            @(negedge clk);
            if (rsp_valid) res_pulses++;
        end
        rst = 1'b0;
        ram_mode = 0;
        repeat (12) begin
            @(negedge clk);
            if (rsp_valid) res_pulses++;
        end
        check("mid_no_rsp", 32'(res_pulses), 32'd0);

        // Illegal size: immediate error, no bus access
        do_req(1'b0, 2'b11, 1'b0, 8'h20, 32'd0);
        check("ill_err", 32'(res_err), 32'd1);
        check("ill_lat", 32'(res_lat), 32'd0);
        check("ill_bus", 32'(res_en_seen), 32'd0);
        check("ill_data", res_data, 32'd0);

        // Misaligned word load
        run_checked("mis_word", 1'b0, 2'b10, 1'b0, 8'h11, 32'd0);
        run_checked("mis_half", 1'b0, 2'b01, 1'b1, 8'h13, 32'd0);

        // Randomized traffic
        for (int i = 0; i < 60; i++) begin
            logic       rw = 1'($urandom_range(0, 1));
            logic [1:0] sz = ($urandom_range(0, 9) == 0) ? 2'b11 : 2'($urandom_range(0, 2));
            logic       sg = 1'($urandom_range(0, 1));
            logic [7:0] ad = 8'($urandom_range(0, 255));
            run_checked("rnd", rw, sz, sg, ad, $urandom);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
        $finish;
    end

endmodule
